// File: rtl/atomic_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atomic_seq_pkg
// Description : Shared op-codes, FSM state encoding and command field helpers
//               for the atomic sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package atomic_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_CAS = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } seq_state_e;

    localparam logic [2:0] c_CAS_OP  = OP_CAS;
    localparam logic [2:0] c_ALU_SUB = OP_SUB;

    // Helpers work on a command zero-extended to the widest supported shape.
    localparam int c_ADDR_MAX_W = 16;
    localparam int c_CMD_MAX_W  = 3 + 3 * c_ADDR_MAX_W;
    localparam int c_SLOT_A3    = 0;
    localparam int c_SLOT_A2    = 1;
    localparam int c_SLOT_A1    = 2;

    function automatic logic [2:0] cmd_op(input logic [c_CMD_MAX_W-1:0] c, input int aw);
        logic [c_CMD_MAX_W-1:0] s;
        s = c >> (3 * aw);
        return s[2:0];
    endfunction

    function automatic logic [c_ADDR_MAX_W-1:0] cmd_field(input logic [c_CMD_MAX_W-1:0] c,
                                                          input int aw, input int slot);
        logic [c_CMD_MAX_W-1:0]  s;
        logic [c_ADDR_MAX_W-1:0] m;
        s = c >> (slot * aw);
        m = ~({c_ADDR_MAX_W{1'b1}} << aw);
        return s[c_ADDR_MAX_W-1:0] & m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/atomic_regfile.sv
`default_nettype none
// ============================================================================
// Module      : atomic_regfile
// Description : NREG x DATA_W register file; one write port plus a status
//               lane into R[NREG-1], two operand reads, one debug read.
// Revision    : 1.0 - initial release
// ============================================================================
module atomic_regfile #(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 8,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              st_en,
    input  logic              st_val,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [NREG];

    // The status lane is applied last so it overrides a same-cycle data write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                r_mem[wr_addr] <= wr_data;
            end
            if (st_en) begin
                r_mem[NREG-1] <= DATA_W'(st_val);
            end
        end
    end

    assign ra_data = r_mem[ra_addr];
    assign rb_data = r_mem[rb_addr];
    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/atomic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : atomic_sequencer
// Description : Issues register-file operands to an external ALU and writes
//               the result back. Define ATOMIC_SEQ_CAS_EN to turn op 3'b111
//               into compare-and-swap.
// Revision    : 1.0 - initial release
// ============================================================================
module atomic_sequencer
    import atomic_seq_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 8,
    localparam int AW     = $clog2(NREG),
    localparam int CMD_W  = 3 + 3 * AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  cmd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [2:0]        alu_op_code,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              alu_req,
    input  logic              alu_ack,
    input  logic [DATA_W-1:0] y,
    input  logic              O,
    input  logic              C,
    input  logic              Z,
    input  logic              N,
    output logic [3:0]        flags,
    output logic              busy,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    seq_state_e              r_state;
    seq_state_e              w_next;
    logic [c_CMD_MAX_W-1:0]  w_cmd_x;
    logic [2:0]              w_in_op;
    logic [AW-1:0]           w_in_a1;
    logic [AW-1:0]           w_in_a2;
    logic [AW-1:0]           w_in_a3;
    logic                    w_in_cas;
    logic [AW-1:0]           r_a3;
    logic [DATA_W-1:0]       r_y;
    logic [3:0]              r_flags;
    logic                    w_accept;
    logic [AW-1:0]           w_rb_addr;
    logic [DATA_W-1:0]       w_ra_data;
    logic [DATA_W-1:0]       w_rb_data;
    logic                    w_wr_en;
    logic [AW-1:0]           w_wr_addr;
    logic [DATA_W-1:0]       w_wr_data;
    logic                    w_st_en;
    logic                    w_st_val;

    assign w_cmd_x = c_CMD_MAX_W'(cmd);
    assign w_in_op = cmd_op(w_cmd_x, AW);
    assign w_in_a1 = AW'(cmd_field(w_cmd_x, AW, c_SLOT_A1));
    assign w_in_a2 = AW'(cmd_field(w_cmd_x, AW, c_SLOT_A2));
    assign w_in_a3 = AW'(cmd_field(w_cmd_x, AW, c_SLOT_A3));

`ifdef ATOMIC_SEQ_CAS_EN
    logic          r_cas;
    logic [AW-1:0] r_a1;
    logic [AW-1:0] r_a2;

    assign w_in_cas = (w_in_op == c_CAS_OP);
    // Port B fetches the expected value at accept and the swap value in WB.
    assign w_rb_addr = (r_state == ST_IDLE) ? (w_in_cas ? w_in_a3 : w_in_a2) : r_a2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cas <= 1'b0;
            r_a1  <= '0;
            r_a2  <= '0;
        end else if (w_accept) begin
            r_cas <= w_in_cas;
            r_a1  <= w_in_a1;
            r_a2  <= w_in_a2;
        end
    end
`else
    assign w_in_cas  = 1'b0;
    assign w_rb_addr = w_in_a2;
`endif

    atomic_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (w_wr_data),
        .st_en   (w_st_en),
        .st_val  (w_st_val),
        .ra_addr (w_in_a1),
        .ra_data (w_ra_data),
        .rb_addr (w_rb_addr),
        .rb_data (w_rb_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_ISSUE;
            ST_ISSUE: if (alu_ack)  w_next = ST_WB;
            ST_WB:    w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == ST_IDLE);
        busy      = (r_state != ST_IDLE);
        w_accept  = cmd_valid && (r_state == ST_IDLE);
        w_wr_en   = 1'b0;
        w_wr_addr = r_a3;
        w_wr_data = r_y;
        w_st_en   = 1'b0;
        w_st_val  = 1'b0;
        if (r_state == ST_WB) begin
`ifdef ATOMIC_SEQ_CAS_EN
            if (r_cas) begin
                // flags[1] is the captured Z: equal means the swap happens.
                w_wr_en   = r_flags[1];
                w_wr_addr = r_a1;
                w_wr_data = w_rb_data;
                w_st_en   = 1'b1;
                w_st_val  = r_flags[1];
            end else begin
                w_wr_en = 1'b1;
            end
`else
            w_wr_en = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_code <= 3'b000;
            data_a      <= '0;
            data_b      <= '0;
            alu_req     <= 1'b0;
            r_a3        <= '0;
            r_y         <= '0;
            r_flags     <= 4'b0000;
        end else begin
            if (w_accept) begin
                alu_op_code <= w_in_cas ? c_ALU_SUB : w_in_op;
                data_a      <= w_ra_data;
                data_b      <= w_rb_data;
                alu_req     <= 1'b1;
                r_a3        <= w_in_a3;
            end
            if ((r_state == ST_ISSUE) && alu_ack) begin
                alu_req <= 1'b0;
                r_y     <= y;
                r_flags <= {O, C, Z, N};
            end
        end
    end

    assign flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_atomic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_atomic_sequencer
// Description : Directed self-checking bench; the bench plays the ALU and
//               supplies hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atomic_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  alu_op_code;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        alu_req;
    logic        alu_ack;
    logic [31:0] y;
    logic        alu_o, alu_c, alu_z, alu_n;
    logic [3:0]  flags;
    logic        busy;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    atomic_sequencer #(.DATA_W(32), .NREG(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .alu_op_code (alu_op_code),
        .data_a      (data_a),
        .data_b      (data_b),
        .alu_req     (alu_req),
        .alu_ack     (alu_ack),
        .y           (y),
        .O           (alu_o),
        .C           (alu_c),
        .Z           (alu_z),
        .N           (alu_n),
        .flags       (flags),
        .busy        (busy),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] mk(input logic [2:0] op, input logic [2:0] a1,
                                       input logic [2:0] a2, input logic [2:0] a3);
        return {op, a1, a2, a3};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_is(input string tag, input int a, input logic [31:0] exp);
        rd_addr = 3'(a);
        #1;
        check_eq(tag, rd_data, exp);
    endtask

    // Full transaction from IDLE; ack after `stall` idle ISSUE cycles.
    task automatic run_op(input logic [11:0] c, input logic [31:0] yv,
                          input logic [3:0] fl, input int stall);
        cmd       = c;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (stall) step();
        alu_ack = 1'b1;
        y       = yv;
        {alu_o, alu_c, alu_z, alu_n} = fl;
        step();
        alu_ack = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; cmd = '0; cmd_valid = 1'b0; alu_ack = 1'b0; y = '0;
        {alu_o, alu_c, alu_z, alu_n} = 4'b0000; rd_addr = '0;
        step(); step();
        rst = 1'b0;
        step();
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_req", 32'(alu_req), 32'd0);
        check_eq("rst_flags", 32'(flags), 32'd0);
        check_eq("rst_op", 32'(alu_op_code), 32'd0);
        check_eq("rst_da", data_a, 32'd0);
        for (int i = 0; i < 8; i++) reg_is("rst_reg", i, 32'd0);

        // ADD R3 = R1 + R2 at minimum latency
        run_op(mk(3'd0, 3'd0, 3'd0, 3'd1), 32'd5, 4'b0000, 0);
        run_op(mk(3'd0, 3'd0, 3'd0, 3'd2), 32'd7, 4'b0000, 0);
        cmd = mk(3'd0, 3'd1, 3'd2, 3'd3); cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check_eq("add_req", 32'(alu_req), 32'd1);
        check_eq("add_ready", 32'(cmd_ready), 32'd0);
        check_eq("add_busy", 32'(busy), 32'd1);
        check_eq("add_op", 32'(alu_op_code), 32'd0);
        check_eq("add_da", data_a, 32'd5);
        check_eq("add_db", data_b, 32'd7);
        alu_ack = 1'b1; y = 32'd12; {alu_o, alu_c, alu_z, alu_n} = 4'b0100;
        step();
        alu_ack = 1'b0;
        check_eq("add_req_drop", 32'(alu_req), 32'd0);
        reg_is("add_nowrite", 3, 32'd0);
        step();
        reg_is("add_r3", 3, 32'd12);
        check_eq("add_ready_back", 32'(cmd_ready), 32'd1);
        check_eq("add_flags", 32'(flags), 32'h4);

        // Ack stalled four cycles
        cmd = mk(3'd2, 3'd2, 3'd1, 3'd4); cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("stall_req", 32'(alu_req), 32'd1);
            check_eq("stall_da", data_a, 32'd7);
            check_eq("stall_db", data_b, 32'd5);
            reg_is("stall_r4", 4, 32'd0);
            step();
        end
        alu_ack = 1'b1; y = 32'hDEAD; {alu_o, alu_c, alu_z, alu_n} = 4'b0001;
        step();
        alu_ack = 1'b0;
        reg_is("stall_r4_pre", 4, 32'd0);
        step();
        reg_is("stall_r4", 4, 32'hDEAD);

        // Ack while idle must be ignored
        alu_ack = 1'b1; y = 32'h1234; {alu_o, alu_c, alu_z, alu_n} = 4'b1111;
        step(); step();
        alu_ack = 1'b0;
        check_eq("idle_ack_busy", 32'(busy), 32'd0);
        check_eq("idle_ack_flags", 32'(flags), 32'h1);
        reg_is("idle_ack_r4", 4, 32'hDEAD);

        // Op 111: compare-and-swap success / fail (or a plain op without CAS)
        run_op(mk(3'd0, 3'd0, 3'd0, 3'd1), 32'd9, 4'b0000, 0);
        run_op(mk(3'd0, 3'd0, 3'd0, 3'd3), 32'd9, 4'b0000, 0);
        run_op(mk(3'd0, 3'd0, 3'd0, 3'd2), 32'h55, 4'b0000, 0);
        cmd = mk(3'd7, 3'd1, 3'd2, 3'd3); cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
`ifdef ATOMIC_SEQ_CAS_EN
        check_eq("cas_op", 32'(alu_op_code), 32'd1);
        check_eq("cas_da", data_a, 32'd9);
        check_eq("cas_db", data_b, 32'd9);
        alu_ack = 1'b1; y = 32'd0; {alu_o, alu_c, alu_z, alu_n} = 4'b0010;
        step(); alu_ack = 1'b0; step();
        reg_is("cas_ok_r1", 1, 32'h55);
        reg_is("cas_ok_r7", 7, 32'd1);
        reg_is("cas_ok_r3", 3, 32'd9);
`else
        check_eq("op7_op", 32'(alu_op_code), 32'd7);
        check_eq("op7_da", data_a, 32'd9);
        check_eq("op7_db", data_b, 32'h55);
        alu_ack = 1'b1; y = 32'h77; {alu_o, alu_c, alu_z, alu_n} = 4'b0010;
        step(); alu_ack = 1'b0; step();
        reg_is("op7_r3", 3, 32'h77);
        reg_is("op7_r1", 1, 32'd9);
        reg_is("op7_r7", 7, 32'd0);
`endif
        run_op(mk(3'd0, 3'd0, 3'd0, 3'd1), 32'd9, 4'b0000, 0);
        run_op(mk(3'd0, 3'd0, 3'd0, 3'd3), 32'd4, 4'b0000, 0);
        cmd = mk(3'd7, 3'd1, 3'd2, 3'd3); cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
`ifdef ATOMIC_SEQ_CAS_EN
        check_eq("casf_db", data_b, 32'd4);
        alu_ack = 1'b1; y = 32'd5; {alu_o, alu_c, alu_z, alu_n} = 4'b0000;
        step(); alu_ack = 1'b0; step();
        reg_is("casf_r1", 1, 32'd9);
        reg_is("casf_r7", 7, 32'd0);
`else
        alu_ack = 1'b1; y = 32'h66; {alu_o, alu_c, alu_z, alu_n} = 4'b0000;
        step(); alu_ack = 1'b0; step();
        reg_is("op7b_r3", 3, 32'h66);
        reg_is("op7b_r1", 1, 32'd9);
`endif

        // Back-to-back with cmd_valid held: second reads first's result
        run_op(mk(3'd0, 3'd0, 3'd0, 3'd1), 32'd3, 4'b0000, 0);
        run_op(mk(3'd0, 3'd0, 3'd0, 3'd2), 32'd4, 4'b0000, 0);
        cmd = mk(3'd0, 3'd1, 3'd2, 3'd3); cmd_valid = 1'b1;
        step();
        cmd = mk(3'd0, 3'd3, 3'd3, 3'd5);
        alu_ack = 1'b1; y = 32'd7;
        step();
        alu_ack = 1'b0;
        check_eq("b2b_wb_ready", 32'(cmd_ready), 32'd0);
        step();
        check_eq("b2b_idle_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check_eq("b2b_da", data_a, 32'd7);
        check_eq("b2b_db", data_b, 32'd7);
        alu_ack = 1'b1; y = 32'd14;
        step(); alu_ack = 1'b0; step();
        reg_is("b2b_r5", 5, 32'd14);
        reg_is("b2b_r3", 3, 32'd7);

        // Reset while in ISSUE wins over ack and cmd_valid
        cmd = mk(3'd0, 3'd1, 3'd2, 3'd6); cmd_valid = 1'b1;
        step();
        check_eq("rsti_req", 32'(alu_req), 32'd1);
        rst = 1'b1; alu_ack = 1'b1; y = 32'hBAD; {alu_o, alu_c, alu_z, alu_n} = 4'b1111;
        step();
        rst = 1'b0; cmd_valid = 1'b0;
        check_eq("rsti_ready", 32'(cmd_ready), 32'd1);
        check_eq("rsti_busy", 32'(busy), 32'd0);
        check_eq("rsti_req0", 32'(alu_req), 32'd0);
        check_eq("rsti_da", data_a, 32'd0);
        check_eq("rsti_flags", 32'(flags), 32'd0);
        for (int i = 0; i < 8; i++) reg_is("rsti_reg", i, 32'd0);
        y = 32'h99;
        step(); step();
        alu_ack = 1'b0;
        check_eq("rsti_late_busy", 32'(busy), 32'd0);
        check_eq("rsti_late_flags", 32'(flags), 32'd0);
        reg_is("rsti_late_r6", 6, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
